// File: rtl/bw_mem_req_arbiter_if.sv
// rtl/bw_mem_req_arbiter_if.sv - request/response bus bundle for the memory request arbiter
interface bw_mem_req_arbiter_if #(
    parameter int NREQ = 4,
    parameter int NOUT = 8
);
    localparam int SW = $clog2(NOUT);

    logic [NREQ-1:0]        req_v_i;
    logic [NREQ-1:0][314:0] req_i;
    logic [NREQ-1:0]        req_rdy_o;
    logic                   mreq_v_o;
    logic [314:0]           mreq_o;
    logic                   mreq_rdy_i;
    logic                   mresp_v_i;
    logic [618:0]           mresp_i;
    logic [NREQ-1:0]        resp_v_o;
    logic [618:0]           resp_o;
    logic [SW:0]            outst_o;
    logic                   err_o;

    // Arbiter side
    modport slave (
        input  req_v_i, req_i, mreq_rdy_i, mresp_v_i, mresp_i,
        output req_rdy_o, mreq_v_o, mreq_o, resp_v_o, resp_o, outst_o, err_o
    );

    // Requester / memory-unit side
    modport master (
        output req_v_i, req_i, mreq_rdy_i, mresp_v_i, mresp_i,
        input  req_rdy_o, mreq_v_o, mreq_o, resp_v_o, resp_o, outst_o, err_o
    );
endinterface

// File: rtl/bw_mem_req_arbiter.sv
// rtl/bw_mem_req_arbiter.sv - round-robin memory request arbiter with tid retagging and response steering
// Packet layout: tid occupies bits [7:0] of both request and response; response bit 8 is cmt.
module bw_mem_req_arbiter #(
    parameter int NREQ = 4,
    parameter int NOUT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    bw_mem_req_arbiter_if.slave   bus
);
    localparam int RW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW      = $clog2(NOUT);
    localparam int CMT_BIT = 8;

    logic [NOUT-1:0] valid_q, valid_d;
    logic [RW-1:0]   port_q [NOUT];
    logic [7:0]      tid_q  [NOUT];
    logic [RW-1:0]   rr_q;
    logic            mreq_v_q;
    logic [314:0]    mreq_q, mreq_d;
    logic [NREQ-1:0] resp_v_q;
    logic [618:0]    resp_q, resp_d;
    logic [SW:0]     outst_q, outst_d;
    logic            err_q;

    logic            has_free;
    logic [SW-1:0]   free_slot;
    logic            found;
    logic [RW-1:0]   win;
    logic            grant;
    logic [SW-1:0]   rs_slot;
    logic            resp_hit;
    logic            resp_free;

    // Lowest-index free table slot, taken from the registered valid mask
    always_comb begin
        has_free  = 1'b0;
        free_slot = '0;
        for (int s = NOUT - 1; s >= 0; s--) begin
            if (!valid_q[s]) begin
                has_free  = 1'b1;
                free_slot = SW'(s);
            end
        end
    end

    // Round-robin winner search starting at the RR pointer
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (int'(rr_q) + i) % NREQ;
            if (!found && bus.req_v_i[idx]) begin
                found = 1'b1;
                win   = RW'(idx);
            end
        end
    end

    assign grant         = rst_ni & found & has_free & (~mreq_v_q | bus.mreq_rdy_i);
    assign bus.req_rdy_o = grant ? (NREQ'(1) << win) : '0;

    assign rs_slot   = bus.mresp_i[SW-1:0];
    assign resp_hit  = bus.mresp_v_i & valid_q[rs_slot] & (bus.mresp_i[7:SW] == '0);
    assign resp_free = resp_hit & bus.mresp_i[CMT_BIT];

    // Next-state payloads, table mask and occupancy
    always_comb begin
        mreq_d       = bus.req_i[win];
        mreq_d[7:0]  = 8'(free_slot);
        resp_d       = bus.mresp_i;
        resp_d[7:0]  = tid_q[rs_slot];
        valid_d      = valid_q;
        if (resp_free) valid_d[rs_slot] = 1'b0;
        if (grant)     valid_d[free_slot] = 1'b1;
        outst_d      = outst_q + (SW+1)'(grant) - (SW+1)'(resp_free);
    end

    // Output registers, transaction table and RR pointer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q  <= '0;
            rr_q     <= '0;
            mreq_v_q <= 1'b0;
            mreq_q   <= '0;
            resp_v_q <= '0;
            resp_q   <= '0;
            outst_q  <= '0;
            err_q    <= 1'b0;
            for (int s = 0; s < NOUT; s++) begin
                port_q[s] <= '0;
                tid_q[s]  <= '0;
            end
        end else begin
            if (grant) begin
                mreq_v_q          <= 1'b1;
                mreq_q            <= mreq_d;
                port_q[free_slot] <= win;
                tid_q[free_slot]  <= bus.req_i[win][7:0];
                rr_q              <= (win == RW'(NREQ - 1)) ? '0 : win + 1'b1;
            end else if (bus.mreq_rdy_i) begin
                mreq_v_q <= 1'b0;
            end
            resp_v_q <= resp_hit ? (NREQ'(1) << port_q[rs_slot]) : '0;
            if (resp_hit) resp_q <= resp_d;
            if (bus.mresp_v_i && !resp_hit) err_q <= 1'b1;
            valid_q <= valid_d;
            outst_q <= outst_d;
        end
    end

    assign bus.mreq_v_o = mreq_v_q;
    assign bus.mreq_o   = mreq_q;
    assign bus.resp_v_o = resp_v_q;
    assign bus.resp_o   = resp_q;
    assign bus.outst_o  = outst_q;
    assign bus.err_o    = err_q;
endmodule

// File: tb/tb_bw_mem_req_arbiter.sv
// tb/tb_bw_mem_req_arbiter.sv - randomized self-checking bench for bw_mem_req_arbiter
module tb_bw_mem_req_arbiter;
    localparam int NREQ = 4;
    localparam int NOUT = 8;
    localparam int SW   = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bw_mem_req_arbiter_if #(.NREQ(NREQ), .NOUT(NOUT)) bus ();

    bw_mem_req_arbiter #(.NREQ(NREQ), .NOUT(NOUT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: table of outstanding transactions plus expected output registers
    bit           m_valid [NOUT];
    int           m_port  [NOUT];
    logic [7:0]   m_tid   [NOUT];
    int           m_rr;
    bit           m_ov;
    logic [314:0] m_od;
    logic [NREQ-1:0] m_rv;
    logic [618:0] m_rd;
    bit           m_err;

    // Requester-side pending packets (held stable until accepted)
    bit           pv   [NREQ];
    logic [314:0] pend [NREQ];

    int  p_slot, p_w;
    bit  p_grant;
    logic [NREQ-1:0] p_rdy;
    bit  force_stale;

    function automatic logic [314:0] rnd_req();
        logic [314:0] r;
        for (int i = 0; i < 315; i++) r[i] = 1'($urandom_range(1, 0));
        return r;
    endfunction

    function automatic logic [618:0] rnd_resp();
        logic [618:0] r;
        for (int i = 0; i < 619; i++) r[i] = 1'($urandom_range(1, 0));
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NOUT; s++) begin
            m_valid[s] = 0; m_port[s] = 0; m_tid[s] = '0;
        end
        m_rr = 0; m_ov = 0; m_od = '0; m_rv = '0; m_rd = '0; m_err = 0;
        for (int p = 0; p < NREQ; p++) pv[p] = 0;
    endtask

    function automatic int model_outst();
        int n = 0;
        for (int s = 0; s < NOUT; s++) n += int'(m_valid[s]);
        return n;
    endfunction

    task automatic predict();
        p_slot = -1;
        for (int s = 0; s < NOUT; s++) if (!m_valid[s] && p_slot < 0) p_slot = s;
        p_w = -1;
        for (int i = 0; i < NREQ; i++) begin
            int p = (m_rr + i) % NREQ;
            if (p_w < 0 && pv[p]) p_w = p;
        end
        p_grant = (p_slot >= 0) && (p_w >= 0) && (!m_ov || bus.mreq_rdy_i);
        p_rdy = '0;
        if (p_grant) p_rdy[p_w] = 1'b1;
    endtask

    task automatic model_step();
        int s;
        bit hit;
        logic [NREQ-1:0] nrv;
        s   = int'(bus.mresp_i[SW-1:0]);
        hit = bus.mresp_v_i && m_valid[s] && (bus.mresp_i[7:SW] == '0);
        nrv = '0;
        if (hit) begin
            nrv[m_port[s]] = 1'b1;
            m_rd = bus.mresp_i;
            m_rd[7:0] = m_tid[s];
            if (bus.mresp_i[8]) m_valid[s] = 0;
        end else if (bus.mresp_v_i) begin
            m_err = 1;
        end
        m_rv = nrv;
        if (p_grant) begin
            m_ov = 1;
            m_od = pend[p_w];
            m_od[7:0] = 8'(p_slot);
            m_valid[p_slot] = 1;
            m_port[p_slot]  = p_w;
            m_tid[p_slot]   = pend[p_w][7:0];
            m_rr = (p_w + 1) % NREQ;
            pv[p_w] = 0;
        end else if (bus.mreq_rdy_i) begin
            m_ov = 0;
        end
    endtask

    task automatic drive(input int pr_req, input int pr_rdy, input int pr_resp, input int pr_bad);
        int r;
        int cand [$];
        logic [618:0] rp;
        for (int p = 0; p < NREQ; p++) begin
            if (!pv[p] && ($urandom % 100) < pr_req) begin
                pv[p] = 1;
                pend[p] = rnd_req();
            end
            bus.req_v_i[p] = pv[p];
            bus.req_i[p]   = pend[p];
        end
        bus.mreq_rdy_i = (($urandom % 100) < pr_rdy);
        bus.mresp_v_i  = 1'b0;
        rp = rnd_resp();
        r  = int'($urandom % 100);
        if (force_stale) begin
            rp[7:0] = 8'h03;
            bus.mresp_v_i = 1'b1;
            force_stale = 0;
        end else if (r < pr_resp) begin
            for (int s = 0; s < NOUT; s++) if (m_valid[s]) cand.push_back(s);
            if (cand.size() > 0) begin
                rp[7:0] = 8'(cand[$urandom_range(cand.size() - 1, 0)]);
                rp[8]   = (($urandom % 3) != 0);
                bus.mresp_v_i = 1'b1;
            end
        end else if (r < pr_resp + pr_bad) begin
            rp[7:0] = {5'($urandom_range(31, 1)), 3'($urandom_range(7, 0))};
            bus.mresp_v_i = 1'b1;
        end
        bus.mresp_i = rp;
    endtask

    task automatic check_outputs();
        check("req_rdy", 640'(bus.req_rdy_o), 640'(p_rdy));
        check("mreq_v",  640'(bus.mreq_v_o),  640'(m_ov));
        check("mreq",    640'(bus.mreq_o),    640'(m_od));
        check("resp_v",  640'(bus.resp_v_o),  640'(m_rv));
        check("resp",    640'(bus.resp_o),    640'(m_rd));
        check("outst",   640'(bus.outst_o),   640'(model_outst()));
        check("err",     640'(bus.err_o),     640'(m_err));
    endtask

    task automatic cycle(input int pr_req, input int pr_rdy, input int pr_resp, input int pr_bad);
        drive(pr_req, pr_rdy, pr_resp, pr_bad);
        #3;
        predict();
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        bus.req_v_i    = '0;
        bus.req_i      = '0;
        bus.mreq_rdy_i = 1'b0;
        bus.mresp_v_i  = 1'b0;
        bus.mresp_i    = '0;
        force_stale    = 0;
        for (int p = 0; p < NREQ; p++) pend[p] = '0;
        model_reset();
        #1;
        predict();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Mixed traffic with frequent responses
        for (int c = 0; c < 400; c++) cycle(70, 80, 60, 0);
        // All requesters busy, immediate acceptance: round-robin rotation
        for (int c = 0; c < 100; c++) cycle(100, 100, 90, 0);
        // Heavy backpressure from the memory unit
        for (int c = 0; c < 200; c++) cycle(80, 15, 40, 0);
        // No responses: table fills and grants stop
        for (int c = 0; c < 40; c++) cycle(90, 100, 0, 0);
        // Drain with sparse responses while full pressure continues
        for (int c = 0; c < 200; c++) cycle(90, 100, 20, 0);

        // Asynchronous reset in the middle of traffic
        drive(100, 100, 50, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req_rdy", 640'(bus.req_rdy_o), 640'(0));
        check("rst_mreq_v",  640'(bus.mreq_v_o),  640'(0));
        check("rst_mreq",    640'(bus.mreq_o),    640'(0));
        check("rst_resp_v",  640'(bus.resp_v_o),  640'(0));
        check("rst_resp",    640'(bus.resp_o),    640'(0));
        check("rst_outst",   640'(bus.outst_o),   640'(0));
        check("rst_err",     640'(bus.err_o),     640'(0));
        model_reset();
        bus.req_v_i   = '0;
        bus.mresp_v_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        force_stale = 1;

        // Traffic after reset, including occasional bogus responses
        for (int c = 0; c < 400; c++) cycle(60, 70, 50, 3);
        for (int c = 0; c < 40; c++) cycle(100, 100, 0, 0);
        for (int c = 0; c < 200; c++) cycle(50, 60, 50, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
